// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting behind the register file.
// Multiply uses a shift-add loop and divide a restoring loop, one step per cycle.
// The result is sign-corrected in a single FIX cycle and presented with a one-cycle done pulse.
// Optional build macro: MULDIV_FAST_MUL_EN computes the full multiply product in the accept
// cycle, so multiplies skip the CALC loop.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int N_ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N_ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        f3;
    logic              sa, sb, spec;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opa, opb, rem, quo;
    logic [2*XLEN-1:0] prod;
    logic [4:0]        rd_lat;

    // Request decode, evaluated on the live operands in the accept cycle
    logic              a_signed, b_signed, divz, ovf, special, fast, accept;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [2*XLEN-1:0] prod_init;

    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign divz     = funct3[2] && (op_b == '0);
    assign ovf      = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
    assign special  = divz || ovf;
    assign a_abs    = (a_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_abs    = (b_signed && op_b[XLEN-1]) ? -op_b : op_b;
    assign accept   = (state == IDLE) && start && !kill;

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product on sign- or zero-extended operands; already carries its sign
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
    assign ext_b     = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
    assign fast_prod = ext_a * ext_b;
    assign fast      = !funct3[2];
    assign prod_init = fast ? fast_prod : {{XLEN{1'b0}}, b_abs};
`else
    assign fast      = 1'b0;
    assign prod_init = {{XLEN{1'b0}}, b_abs};
`endif

    // One shift-add step: add multiplicand into the high half when the low bit is set, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nx;
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod[0]}} & opa};
    assign mul_nx  = {mul_sum, prod[XLEN-1:1]};

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract
    logic [XLEN:0]   r_sh, trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx, quo_nx;
    assign r_sh   = {rem, quo[XLEN-1]};
    assign trial  = r_sh - {1'b0, opb};
    assign q_bit  = ~trial[XLEN];
    assign rem_nx = q_bit ? trial[XLEN-1:0] : r_sh[XLEN-1:0];
    assign quo_nx = {quo[XLEN-2:0], q_bit};

    // Sign correction and output select, used in FIX
    logic [2*XLEN-1:0] prod_sel;
    logic [XLEN-1:0]   res_fix;
    assign prod_sel = (sa ^ sb) ? -prod : prod;

    // Pick the architectural result for the latched operation
    always_comb begin
        res_fix = '0;
        case (f3)
            3'b000:                 res_fix = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_fix = prod_sel[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_fix = (spec || !(sa ^ sb)) ? quo : -quo;
            default:                res_fix = (spec || !sa) ? rem : -rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; kill overrides everything
    always_comb begin
        state_nx = state;
        if (kill) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = (special || fast) ? FIX : CALC;
                CALC:    if (cnt == '0) state_nx = FIX;
                FIX:     state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: capture on accept, iterate in CALC, commit result and rd in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            spec   <= 1'b0;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            quo    <= '0;
            prod   <= '0;
            rd_lat <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            f3     <= funct3;
            sa     <= a_signed && op_a[XLEN-1] && !fast;
            sb     <= b_signed && op_b[XLEN-1] && !fast;
            spec   <= special;
            cnt    <= CNT_INIT;
            opa    <= a_abs;
            opb    <= b_abs;
            prod   <= prod_init;
            rd_lat <= rd_in;
            quo    <= divz ? '1 : (ovf ? INT_MIN : a_abs);
            rem    <= divz ? op_a : '0;
        end else if (!kill && state == CALC) begin
            cnt <= cnt - 1'b1;
            if (f3[2]) begin
                rem <= rem_nx;
                quo <= quo_nx;
            end else begin
                prod <= mul_nx;
            end
        end else if (!kill && state == FIX) begin
            result <= res_fix;
            rd_out <= rd_lat;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit against a cycle-level reference model
// built from signed/unsigned 64-bit arithmetic and latency counting.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LMUL = 2;
`else
    localparam int LMUL = 34;
`endif
    localparam int LDIV = 34;
    localparam int LSPC = 2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests = 0, fails = 0, cyc = 0;

    muldiv_unit #(.XLEN(XLEN), .N_ITER(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, p;
        logic [63:0] up;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % longint'({32'd0, b}); return p[31:0];
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return LSPC;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LSPC;
        if (!f[2]) return LMUL;
        return LDIV;
    endfunction

    // Reference model: one op in flight, done in the cycle lat after the accept cycle
    logic        m_pend = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res_nx = '0, m_res = '0;
    logic [4:0]  m_rd_nx = '0, m_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_left <= 0; m_res <= '0; m_rd <= '0;
        end else if (kill) begin
            m_pend <= 1'b0;
        end else if (!m_pend) begin
            if (start) begin
                m_pend   <= 1'b1;
                m_left   <= lat_of(funct3, op_a, op_b) - 1;
                m_res_nx <= ref_op(funct3, op_a, op_b);
                m_rd_nx  <= rd_in;
            end
        end else if (m_left == 0) begin
            m_pend <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res <= m_res_nx;
                m_rd  <= m_rd_nx;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_pend});
        chk("done", {31'd0, done}, {31'd0, m_pend && m_left == 0});
        chk("result", result, m_res);
        chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
    end

    int c0;

    // Present one request for a single cycle, then scramble the operand inputs
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        funct3 = 3'($urandom);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
        bit got;
        start_op(f, a, b, rd);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({nm, "_done"}, {31'd0, got}, 32'd1);
        chk({nm, "_lat"}, cyc - c0, exp_lat);
        chk({nm, "_res"}, result, exp_res);
        chk({nm, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        @(negedge clk);
    endtask

    int ndone;
    logic [31:0] seen;

    initial begin
        // Pin the model to hand-computed values
        chk("model_mulh", ref_op(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model_rem", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        #2 rst_n = 1'b1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, LMUL);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, LMUL);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, LMUL);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, LMUL);
        run_op("mul_rd0", 3'd0, 32'd1234, 32'd1000, 5'd0, 32'd1234000, LMUL);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, LDIV);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, LDIV);
        run_op("divu", 3'd5, 32'd7, 32'd2, 5'd11, 32'd3, LDIV);
        run_op("remu", 3'd7, 32'd7, 32'd2, 5'd12, 32'd1, LDIV);
        run_op("divu_z", 3'd5, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF, LSPC);
        run_op("remu_z", 3'd7, 32'd9, 32'd0, 5'd14, 32'd9, LSPC);
        run_op("div_z", 3'd4, 32'hFFFF_FFF0, 32'd0, 5'd15, 32'hFFFF_FFFF, LSPC);
        run_op("rem_z", 3'd6, 32'hFFFF_FFF0, 32'd0, 5'd16, 32'hFFFF_FFF0, LSPC);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, LSPC);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, LSPC);
        run_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, LDIV);

        // Second start while busy is ignored
        start_op(3'd4, 32'd100, 32'd7, 5'd3);
        repeat (9) @(negedge clk);
        funct3 = 3'd7; op_a = 32'd9; op_b = 32'd4; rd_in = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; seen = '0;
        repeat (60) begin
            if (done) begin ndone++; seen = result; end
            @(negedge clk);
        end
        chk("ignore_ndone", ndone, 32'd1);
        chk("ignore_res", seen, 32'd14);

        // Kill mid-divide: no done, outputs keep the previous op
        start_op(3'd4, 32'd1000, 32'd3, 5'd9);
        repeat (14) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        ndone = 0;
        repeat (50) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("kill_ndone", ndone, 32'd0);
        chk("kill_res", result, 32'd14);
        chk("kill_rd", {27'd0, rd_out}, 32'd3);

        // Kill and start together: nothing accepted
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd4; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("killstart_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);

        // Reset mid-op clears outputs without waiting for an edge
        start_op(3'd5, 32'd50, 32'd5, 5'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_op("post_rst", 3'd7, 32'd7, 32'd2, 5'd21, 32'd1, LDIV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no end expected end of run");
        $fatal(1);
    end

endmodule
